// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: shared datapath widths and ALU control codes
package alu_share_arb_pkg;
  localparam int DATA_W = 64;
  localparam int CTRL_W = 4;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0111;
endpackage

// File: rtl/alu_share_arb_alu.sv
// alu_share_arb_alu: 64-bit combinational ALU (ctrl/op1/op2 in, res out; unknown codes give 0)
module alu_share_arb_alu
  import alu_share_arb_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] res
);
  always_comb
    case (ctrl)
      ALU_ADD:  res = op1 + op2;
      ALU_SUB:  res = op1 - op2;
      ALU_SLL:  res = op1 << op2;
      ALU_SLT:  res = {{(DATA_W-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU: res = {{(DATA_W-1){1'b0}}, op1 < op2};
      ALU_XOR:  res = op1 ^ op2;
      ALU_SRL:  res = op1 >> op2;
      ALU_SRA:  res = $signed(op1) >>> op2;
      ALU_OR:   res = op1 | op2;
      ALU_AND:  res = op1 & op2;
      default:  res = '0;
    endcase
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin share of one ALU between two valid/ready clients, each with a one-entry result buffer; busy_o flags any unconsumed result
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter logic PRIO_RST = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_op1_i,
  input  logic [DATA_W-1:0] req0_op2_i,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  output logic              resp0_valid_o,
  input  logic              resp0_ready_i,
  output logic [DATA_W-1:0] resp0_data_o,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_op1_i,
  input  logic [DATA_W-1:0] req1_op2_i,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  output logic              resp1_valid_o,
  input  logic              resp1_ready_i,
  output logic [DATA_W-1:0] resp1_data_o,
  output logic              busy_o
);
  logic e0, e1, g0, g1, prio;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] op1, op2, res;
  assign e0 = req0_valid_i & (~resp0_valid_o | resp0_ready_i);
  assign e1 = req1_valid_i & (~resp1_valid_o | resp1_ready_i);
  assign g0 = e0 & (~e1 | ~prio);
  assign g1 = e1 & (~e0 | prio);
  assign req0_ready_o = g0;
  assign req1_ready_o = g1;
  assign op1  = g0 ? req0_op1_i  : g1 ? req1_op1_i  : '0;
  assign op2  = g0 ? req0_op2_i  : g1 ? req1_op2_i  : '0;
  assign ctrl = g0 ? req0_ctrl_i : g1 ? req1_ctrl_i : '0;
  assign busy_o = resp0_valid_o | resp1_valid_o;
  alu_share_arb_alu u_alu (.ctrl(ctrl), .op1(op1), .op2(op2), .res(res));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      prio          <= PRIO_RST;
      resp0_valid_o <= 1'b0;
      resp1_valid_o <= 1'b0;
      resp0_data_o  <= '0;
      resp1_data_o  <= '0;
    end else begin
      prio          <= g0 ? 1'b1 : g1 ? 1'b0 : prio;
      resp0_valid_o <= g0 | (resp0_valid_o & ~resp0_ready_i);
      resp1_valid_o <= g1 | (resp1_valid_o & ~resp1_ready_i);
      resp0_data_o  <= g0 ? res : resp0_data_o;
      resp1_data_o  <= g1 ? res : resp1_data_o;
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: table-driven and scoreboard checks of the shared-ALU arbiter
module tb_alu_share_arb;
  localparam logic PRIO = 1'b0;
  typedef struct {
    string       nm;
    logic [3:0]  c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] y;
  } vec_t;
  logic clk_i = 0, rst_ni = 1;
  logic v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [63:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, exp0 = 0, exp1 = 0;
  logic [3:0] c0 = 0, c1 = 0;
  logic req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, busy_o;
  logic [63:0] resp0_data_o, resp1_data_o;
  logic [63:0] q0[$], q1[$];
  int n_cmp = 0, n_bad = 0;
  logic turn;
  vec_t tbl[14];
  alu_share_arb #(.PRIO_RST(PRIO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_valid_i(v0), .req0_ready_o(req0_ready_o), .req0_op1_i(a0), .req0_op2_i(b0), .req0_ctrl_i(c0),
    .resp0_valid_o(resp0_valid_o), .resp0_ready_i(rr0), .resp0_data_o(resp0_data_o),
    .req1_valid_i(v1), .req1_ready_o(req1_ready_o), .req1_op1_i(a1), .req1_op2_i(b1), .req1_ctrl_i(c1),
    .resp1_valid_o(resp1_valid_o), .resp1_ready_i(rr1), .resp1_data_o(resp1_data_o),
    .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  always @(negedge clk_i)
    if (rst_ni) begin
      if (resp0_valid_o && rr0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp0_unexpected: got %h want none", resp0_data_o);
        end else chk("resp0_sb", resp0_data_o, q0.pop_front());
      end
      if (resp1_valid_o && rr1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp1_unexpected: got %h want none", resp1_data_o);
        end else chk("resp1_sb", resp1_data_o, q1.pop_front());
      end
      if (v0 && req0_ready_o) q0.push_back(exp0);
      if (v1 && req1_ready_o) q1.push_back(exp1);
    end
  initial begin
    tbl[0]  = '{"sub",     4'b1000, 64'd10, 64'd3, 64'd7};
    tbl[1]  = '{"add_wrap", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    tbl[2]  = '{"sll",     4'b0001, 64'd1, 64'd4, 64'd16};
    tbl[3]  = '{"slt_neg", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
    tbl[4]  = '{"sltu",    4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    tbl[5]  = '{"xor",     4'b0100, 64'hF0, 64'h0F, 64'hFF};
    tbl[6]  = '{"srl",     4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'd1};
    tbl[7]  = '{"sra",     4'b1101, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[8]  = '{"or",      4'b0110, 64'hF0, 64'h0F, 64'hFF};
    tbl[9]  = '{"and",     4'b0111, 64'hF0, 64'h3C, 64'h30};
    tbl[10] = '{"slt",     4'b0010, 64'd1, 64'd2, 64'd1};
    tbl[11] = '{"sll_big", 4'b0001, 64'd1, 64'd64, 64'd0};
    tbl[12] = '{"illegal", 4'b1111, 64'd5, 64'd5, 64'd0};
    tbl[13] = '{"ill_1001", 4'b1001, 64'd7, 64'd2, 64'd0};
    #1 rst_ni = 0;
    #2;
    chk("rst_valid0", {63'd0, resp0_valid_o}, 64'd0);
    chk("rst_valid1", {63'd0, resp1_valid_o}, 64'd0);
    chk("rst_data0", resp0_data_o, 64'd0);
    chk("rst_data1", resp1_data_o, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    step();
    rst_ni = 1;
    rr0 = 1; rr1 = 1;
    for (int i = 0; i < 14; i++) begin
      v0 = 1; c0 = tbl[i].c; a0 = tbl[i].a; b0 = tbl[i].b; exp0 = tbl[i].y;
      #1 chk({"gnt_", tbl[i].nm}, {63'd0, req0_ready_o}, 64'd1);
      step();
      chk({"valid_", tbl[i].nm}, {63'd0, resp0_valid_o}, 64'd1);
      chk({"data_", tbl[i].nm}, resp0_data_o, tbl[i].y);
    end
    v0 = 0;
    step();
    v0 = 1; c0 = 4'b0000; a0 = 64'd1; b0 = 64'd1; exp0 = 64'd2; rr0 = 0;
    step();
    v0 = 0;
    chk("mid_valid", {63'd0, resp0_valid_o}, 64'd1);
    chk("mid_busy", {63'd0, busy_o}, 64'd1);
    #2 rst_ni = 0;
    q0.delete(); q1.delete();
    #1;
    chk("async_valid0", {63'd0, resp0_valid_o}, 64'd0);
    chk("async_data0", resp0_data_o, 64'd0);
    chk("async_busy", {63'd0, busy_o}, 64'd0);
    step();
    step();
    rst_ni = 1; rr0 = 1; rr1 = 1;
    v0 = 1; c0 = 4'b0100; a0 = 64'hF0; b0 = 64'h0F; exp0 = 64'hFF;
    v1 = 1; c1 = 4'b0001; a1 = 64'd1; b1 = 64'd4; exp1 = 64'd16;
    turn = PRIO;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("cont_g0", {63'd0, req0_ready_o}, {63'd0, turn == 1'b0});
      chk("cont_g1", {63'd0, req1_ready_o}, {63'd0, turn == 1'b1});
      step();
      turn = ~turn;
    end
    v0 = 0; c1 = 4'b0000; a1 = 64'd5; b1 = 64'd6; exp1 = 64'd11;
    #1 chk("bp_first_g1", {63'd0, req1_ready_o}, 64'd1);
    step();
    rr1 = 0; c1 = 4'b1000; a1 = 64'd20; b1 = 64'd5; exp1 = 64'd15;
    v0 = 1; c0 = 4'b0111; a0 = 64'hF0; b0 = 64'h3C; exp0 = 64'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_g1_low", {63'd0, req1_ready_o}, 64'd0);
      chk("bp_g0_high", {63'd0, req0_ready_o}, 64'd1);
      chk("bp_hold1", resp1_data_o, 64'd11);
      step();
    end
    rr1 = 1;
    #1;
    chk("bp_release_g1", {63'd0, req1_ready_o}, 64'd1);
    chk("bp_release_g0", {63'd0, req0_ready_o}, 64'd0);
    step();
    v0 = 0; v1 = 0;
    repeat (3) step();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("end_busy", {63'd0, busy_o}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester round-robin arbiter that time-shares one 64-bit integer ALU instance between two clients (e.g. main execute path and an address/branch helper path).
- Each client has a valid/ready request channel carrying two operands and a 4-bit ALU control code.
- Each client also has a valid/ready response channel with a one-entry registered result buffer.
- Sits between the decode/issue logic and the shared ALU in the multicycle core variant.

Parameters:
- DATA_W, 64, operand/result width; fixed at 64 to match the ALU.
- CTRL_W, 4, ALU control code width.
- PRIO_RST, 0, requester index holding priority after reset (0 or 1).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req0_valid_i  input  1  client 0 request valid.
- req0_ready_o  output  1  client 0 request accepted this cycle when high together with valid.
- req0_op1_i  input  DATA_W  client 0 operand 1.
- req0_op2_i  input  DATA_W  client 0 operand 2.
- req0_ctrl_i  input  CTRL_W  client 0 ALU control code.
- resp0_valid_o  output  1  client 0 result valid.
- resp0_ready_i  input  1  client 0 result consumed.
- resp0_data_o  output  DATA_W  client 0 result.
- req1_* / resp1_*: same set of ports as client 0, for client 1.
- busy_o  output  1  high when either response buffer holds an unconsumed result.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - resp0/1_valid_o = 0.
  - resp0/1_data_o = 0.
  - Priority pointer = PRIO_RST.
  - busy_o = 0.
  - Reset applied mid-transaction discards buffered results; no response is produced for requests accepted before reset.
- Eligibility: client k is eligible when reqk_valid_i = 1 and its response buffer can accept data, i.e. respk_valid_o = 0 OR respk_ready_i = 1.
- Grant (combinational, at most one per cycle):
  - Only one client eligible: grant it.
  - Both eligible: grant the client named by the priority pointer.
  - Neither eligible: no grant.
- reqk_ready_o = grant_k. A ready may depend on valid; valids must not depend on readies.
- Priority pointer: after a grant to client k, the pointer moves to the other client. With no grant, the pointer holds.
- Datapath: the granted client's op1/op2/ctrl are muxed into the single ALU. With no grant, the ALU inputs are driven to 0 with ctrl 0.
- ALU control codes:
  - 0000 add; 1000 sub; 0001 sll; 0010 slt; 0011 sltu; 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and.
  - Any other code produces result 0.
  - Shift amount is the full op2 value; results wrap modulo 2^64.
- Latency: a request accepted at edge N has its result in respk_data_o with respk_valid_o = 1 after edge N, i.e. one cycle.
- Response buffer k:
  - Load on grant_k.
  - Otherwise clear valid on respk_valid_o & respk_ready_i.
  - Simultaneous drain and load in the same cycle: the new result replaces the old one and valid stays 1, giving full throughput of one operation per cycle per client when the client always consumes.
  - Data holds while valid = 1 and ready = 0.
  - Data is not cleared when valid drops.
- Starvation bound: with both clients continuously eligible, grants alternate 0,1,0,1...
- busy_o = resp0_valid_o | resp1_valid_o, registered-derived with no combinational input path.

Decomposition:
- Shared package:
  - ALU control code constants (ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND).
  - DATA_W and CTRL_W.
- Sub-module: the team's existing 64-bit combinational ALU module, instantiated once. No logic is duplicated in this block.
- Arbitration and the two response buffers stay in this module. The buffer may be a small local generate loop rather than a separate module.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert rst_ni = 0 while resp0_valid_o = 1.
  - Required: resp0_valid_o = 0, resp0_data_o = 0, busy_o = 0 immediately, without waiting for a clock edge.
  - After release, the first contended grant goes to PRIO_RST.
- Single client:
  - Stimulus: client 0 sub, op1 = 10, op2 = 3, ctrl 1000, resp0_ready_i = 1.
  - Required: req0_ready_o = 1 the same cycle; next cycle resp0_valid_o = 1, resp0_data_o = 7.
  - Follow-on: add 64'hFFFF_FFFF_FFFF_FFFF + 1 returns 0.
- Contention:
  - Stimulus: both clients valid every cycle, both ready; client 0 xor F0^0F, client 1 sll 1<<4.
  - Required: grants alternate starting at PRIO_RST; resp0 = 8'hFF, resp1 = 16, each every other cycle.
- Backpressure:
  - Stimulus: resp1_ready_i = 0 with resp1 full, and a new req1 valid.
  - Required: req1_ready_o = 0; client 0 is granted every cycle; resp1_data_o holds stable.
  - On raising resp1_ready_i, req1 is granted the same cycle.
- Back-to-back same client:
  - Stimulus: client 0 issues or, and, slt (1 < 2) on consecutive cycles with ready = 1.
  - Required: results appear on consecutive cycles with valid held high: or result, and result, then 1.
- Illegal code:
  - Stimulus: ctrl 4'b1111, op1 = 5, op2 = 5.
  - Required: result 0, normal handshake.
